// File: rtl/matmul_pkg.sv
// Shared types and limits for the matmul sequencer: dimension/index widths,
// the FSM state encoding and the dimension legality rule.
package matmul_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_N      = 256;
    localparam int MAX_M      = 256;
    localparam int MAX_K      = 256;

    localparam int MAX_NM  = (MAX_N > MAX_M) ? MAX_N : MAX_M;
    localparam int MAX_ALL = (MAX_NM > MAX_K) ? MAX_NM : MAX_K;
    localparam int DW      = $clog2(MAX_ALL + 1);
    localparam int IW      = $clog2(MAX_ALL);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [DW-1:0]         dim_t;
    typedef logic [IW-1:0]         idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic dims_legal(input dim_t n, input dim_t m,
                                        input dim_t j, input dim_t k);
        return (m == j) && (n != '0) && (m != '0) && (k != '0) &&
               (n <= dim_t'(MAX_N)) && (m <= dim_t'(MAX_M)) && (k <= dim_t'(MAX_K));
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register shift line; every stage is cleared by reset so no
// stale strobe can emerge after an abort.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: unlike a data RAM, this array carries strobes, so every entry is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Matmul sequencer: walks i (rows of A), c (cols of B), p (inner) and drives
// operand reads, accumulator clear/enable and the C write strobe.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] n_dim,
    input  logic [DW-1:0] m_dim,
    input  logic [DW-1:0] j_dim,
    input  logic [DW-1:0] k_dim,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [IW-1:0] a_row,
    output logic [IW-1:0] a_col,
    output logic [IW-1:0] b_row,
    output logic [IW-1:0] b_col,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          wr_en,
    output logic [IW-1:0] c_row,
    output logic [IW-1:0] c_col
);

    localparam int             DCW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MEM_LAT - 1);

    state_t         state, state_nxt;
    idx_t           i_q, c_q, p_q;
    idx_t           n_last, m_last, k_last;
    logic [DCW-1:0] drain_q;
    logic           err_q;
    logic           legal, p_end, c_end, i_end, drain_end, first_p;
    logic [1:0]     pipe_out;

    // Limits are held as dim-1 so a full 256 still fits the IW-bit counters.
    assign legal     = dims_legal(n_dim, m_dim, j_dim, k_dim);
    assign p_end     = (p_q == m_last);
    assign c_end     = (c_q == k_last);
    assign i_end     = (i_q == n_last);
    assign drain_end = (drain_q == DRAIN_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default at the top of each always_comb keeps every path assigned,
    // so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = legal ? S_READ : S_DONE;
            S_READ:  if (p_end) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (c_end && i_end) ? S_DONE : S_READ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        rd_en   = (state == S_READ);
        wr_en   = (state == S_WRITE);
        first_p = (state == S_READ) && (p_q == '0);
        err     = err_q;
        a_row   = i_q;
        a_col   = p_q;
        b_row   = p_q;
        b_col   = c_q;
        c_row   = i_q;
        c_col   = c_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            drain_q <= '0;
            n_last  <= '0;
            m_last  <= '0;
            k_last  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        c_q     <= '0;
                        p_q     <= '0;
                        drain_q <= '0;
                        n_last  <= idx_t'(n_dim - dim_t'(1));
                        m_last  <= idx_t'(m_dim - dim_t'(1));
                        k_last  <= idx_t'(k_dim - dim_t'(1));
                        err_q   <= !legal;
                    end
                end
                S_READ:  p_q <= p_end ? '0 : p_q + idx_t'(1);
                S_DRAIN: drain_q <= drain_end ? '0 : drain_q + DCW'(1);
                S_WRITE: begin
                    if (c_end) begin
                        c_q <= '0;
                        i_q <= i_end ? '0 : i_q + idx_t'(1);
                    end else begin
                        c_q <= c_q + idx_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_delay #(
        .WIDTH (2),
        .DEPTH (MEM_LAT)
    ) u_mac_pipe (
        .clk   (clk),
        .reset (reset),
        .din   ({rd_en, first_p}),
        .dout  (pipe_out)
    );

    assign {mac_en, mac_clr} = pipe_out;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: two instances (MEM_LAT=1 and 2) share
// stimulus; expected write/done events are queued and checked by a monitor.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    typedef struct {
        bit     is_done;
        int     row;
        int     col;
        bit     err;
        longint cyc;
        int     rd;
        int     clr;
    } ev_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] n_dim = '0, m_dim = '0, j_dim = '0, k_dim = '0;

    logic          busy_w [2], done_w [2], err_w [2], rd_en_w [2];
    logic          mac_en_w [2], mac_clr_w [2], wr_en_w [2];
    logic [IW-1:0] a_row_w [2], a_col_w [2], b_row_w [2], b_col_w [2];
    logic [IW-1:0] c_row_w [2], c_col_w [2];

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    longint t0          = 0;
    int     job_n = 1, job_m = 1, job_k = 1;

    ev_t        sb0 [$];
    ev_t        sb1 [$];
    int         mi [2], mc [2], mp [2], rd_cnt [2], clr_cnt [2];
    logic [3:0] h_rd [2], h_fp [2];

    matmul_seq_ctrl #(.MEM_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .n_dim(n_dim), .m_dim(m_dim), .j_dim(j_dim), .k_dim(k_dim),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .rd_en(rd_en_w[0]),
        .a_row(a_row_w[0]), .a_col(a_col_w[0]), .b_row(b_row_w[0]), .b_col(b_col_w[0]),
        .mac_en(mac_en_w[0]), .mac_clr(mac_clr_w[0]), .wr_en(wr_en_w[0]),
        .c_row(c_row_w[0]), .c_col(c_col_w[0])
    );

    matmul_seq_ctrl #(.MEM_LAT(2)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .n_dim(n_dim), .m_dim(m_dim), .j_dim(j_dim), .k_dim(k_dim),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .rd_en(rd_en_w[1]),
        .a_row(a_row_w[1]), .a_col(a_col_w[1]), .b_row(b_row_w[1]), .b_col(b_col_w[1]),
        .mac_en(mac_en_w[1]), .mac_clr(mac_clr_w[1]), .wr_en(wr_en_w[1]),
        .c_row(c_row_w[1]), .c_col(c_col_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic pop_ev(input int d, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (d == 0 && sb0.size() != 0) begin e = sb0.pop_front(); ok = 1'b1; end
        if (d == 1 && sb1.size() != 0) begin e = sb1.pop_front(); ok = 1'b1; end
    endtask

    // Called in cycle 0 (just after an edge): queues expectations, pulses start.
    task automatic launch(input int n, input int m, input int j, input int k, input bit expect_ev);
        bit  ok;
        int  per;
        ev_t e;
        ok = (m == j) && (n > 0) && (m > 0) && (k > 0) && (n <= 256) && (m <= 256) && (k <= 256);
        t0 = cyc;
        if (ok) begin job_n = n; job_m = m; job_k = k; end
        if (expect_ev) begin
            for (int d = 0; d < 2; d++) begin
                per = m + (d + 1) + 1;
                if (ok) begin
                    for (int el = 0; el < n * k; el++) begin
                        e = '{is_done: 1'b0, row: el / k, col: el % k, err: 1'b0,
                              cyc: t0 + longint'((el + 1) * per), rd: 0, clr: 0};
                        push_ev(d, e);
                    end
                    e = '{is_done: 1'b1, row: 0, col: 0, err: 1'b0,
                          cyc: t0 + longint'(n * k * per) + 1, rd: n * k * m, clr: n * k};
                end else begin
                    e = '{is_done: 1'b1, row: 0, col: 0, err: 1'b1, cyc: t0 + 1, rd: 0, clr: 0};
                end
                push_ev(d, e);
            end
        end
        n_dim = DW'(n);
        m_dim = DW'(m);
        j_dim = DW'(j);
        k_dim = DW'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy_w[0] || busy_w[1]) && n < budget);
        check($sformatf("%s idle within budget", tag), 64'(busy_w[0] | busy_w[1]), 64'(0));
        check($sformatf("%s dut0 pending events", tag), 64'(sb0.size()), 64'(0));
        check($sformatf("%s dut1 pending events", tag), 64'(sb1.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s dut%0d outputs", tag, d),
                  64'({busy_w[d], done_w[d], err_w[d], rd_en_w[d], mac_en_w[d], mac_clr_w[d],
                       wr_en_w[d], a_row_w[d], a_col_w[d], b_row_w[d], b_col_w[d],
                       c_row_w[d], c_col_w[d]}), 64'(0));
    endtask

    task automatic mon_step(input int d);
        int   lat;
        logic exp_mac, exp_clr, cur_fp;
        ev_t  e;
        bit   ok;
        lat = d + 1;
        if (reset) begin
            mi[d] = 0; mc[d] = 0; mp[d] = 0;
            rd_cnt[d] = 0; clr_cnt[d] = 0;
            h_rd[d] = '0; h_fp[d] = '0;
            return;
        end
        exp_mac = h_rd[d][lat-1];
        exp_clr = h_fp[d][lat-1];
        if (mac_en_w[d] || exp_mac)
            check($sformatf("dut%0d mac_en/mac_clr @%0d", d, cyc - t0),
                  64'({mac_en_w[d], mac_clr_w[d]}), 64'({exp_mac, exp_clr}));
        if (mac_en_w[d] && mac_clr_w[d]) clr_cnt[d]++;
        cur_fp = rd_en_w[d] && (mp[d] == 0);
        if (rd_en_w[d]) begin
            check($sformatf("dut%0d rd index a_row,a_col,b_row,b_col", d),
                  64'({a_row_w[d], a_col_w[d], b_row_w[d], b_col_w[d]}),
                  64'({IW'(mi[d]), IW'(mp[d]), IW'(mp[d]), IW'(mc[d])}));
            rd_cnt[d]++;
            if (mp[d] == job_m - 1) begin
                mp[d] = 0;
                if (mc[d] == job_k - 1) begin
                    mc[d] = 0;
                    mi[d] = (mi[d] == job_n - 1) ? 0 : mi[d] + 1;
                end else begin
                    mc[d]++;
                end
            end else begin
                mp[d]++;
            end
        end
        h_rd[d] = {h_rd[d][2:0], rd_en_w[d]};
        h_fp[d] = {h_fp[d][2:0], cur_fp};
        if (wr_en_w[d]) begin
            pop_ev(d, e, ok);
            check($sformatf("dut%0d wr_en expected", d), 64'({ok, e.is_done}), 64'(2'b10));
            check($sformatf("dut%0d wr_en c_row,c_col", d),
                  64'({c_row_w[d], c_col_w[d]}), 64'({IW'(e.row), IW'(e.col)}));
            check($sformatf("dut%0d wr_en cycle", d), 64'(cyc - t0), 64'(e.cyc - t0));
        end
        if (done_w[d]) begin
            pop_ev(d, e, ok);
            check($sformatf("dut%0d done expected", d), 64'({ok, e.is_done}), 64'(2'b11));
            check($sformatf("dut%0d done cycle", d), 64'(cyc - t0), 64'(e.cyc - t0));
            check($sformatf("dut%0d err with done", d), 64'(err_w[d]), 64'(e.err));
            check($sformatf("dut%0d rd_en count", d), 64'(rd_cnt[d]), 64'(e.rd));
            check($sformatf("dut%0d mac_clr count", d), 64'(clr_cnt[d]), 64'(e.clr));
            rd_cnt[d]  = 0;
            clr_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check_all_zero("reset");

        // 1x1 * 1x1 with explicit latency checks
        launch(1, 1, 1, 1, 1'b1);
        check("t1 cyc1 dut0 rd_en,busy", 64'({rd_en_w[0], busy_w[0]}), 64'(2'b11));
        check("t1 cyc1 dut0 indices", 64'({a_row_w[0], a_col_w[0], b_row_w[0], b_col_w[0]}), 64'(0));
        tick();
        check("t1 cyc2 dut0 mac_en,mac_clr", 64'({mac_en_w[0], mac_clr_w[0]}), 64'(2'b11));
        check("t1 cyc2 dut1 mac_en", 64'(mac_en_w[1]), 64'(0));
        tick();
        check("t1 cyc3 dut0 wr_en", 64'(wr_en_w[0]), 64'(1));
        check("t1 cyc3 dut1 mac_en,mac_clr", 64'({mac_en_w[1], mac_clr_w[1]}), 64'(2'b11));
        wait_idle("t1", 3000);

        // 2x3 * 3x2 with a stray start while busy
        launch(2, 3, 3, 2, 1'b1);
        repeat (6) tick();
        n_dim = DW'(1); m_dim = DW'(1); j_dim = DW'(1); k_dim = DW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t2", 3000);

        // m != j: err held until the next accepted start
        launch(2, 3, 4, 2, 1'b1);
        wait_idle("t3", 3000);
        repeat (3) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("t3 dut%0d err held, done low", d),
                      64'({err_w[d], done_w[d]}), 64'(2'b10));
            tick();
        end

        // zero dims, oversize n, then a clean job clears err
        launch(0, 0, 0, 0, 1'b1);
        wait_idle("t4 zero", 3000);
        launch(257, 2, 2, 2, 1'b1);
        wait_idle("t4 oversize", 3000);
        launch(2, 2, 2, 2, 1'b1);
        check("t4 err cleared at accept", 64'({err_w[0], err_w[1]}), 64'(0));
        wait_idle("t4 2x2", 3000);

        // reset mid-job
        launch(4, 4, 4, 4, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("t5 cyc4");
        repeat (10) tick();
        check_all_zero("t5 idle");
        launch(1, 1, 1, 1, 1'b1);
        wait_idle("t5 1x1", 3000);

        // maximum-size dimensions one at a time, oversize m/k, odd shape
        launch(256, 1, 1, 1, 1'b1);
        wait_idle("t6 n256", 3000);
        launch(1, 256, 256, 1, 1'b1);
        wait_idle("t6 m256", 3000);
        launch(1, 1, 1, 256, 1'b1);
        wait_idle("t6 k256", 3000);
        launch(1, 257, 257, 1, 1'b1);
        wait_idle("t6 m257", 3000);
        launch(1, 1, 1, 257, 1'b1);
        wait_idle("t6 k257", 3000);
        launch(3, 2, 2, 3, 1'b1);
        wait_idle("t6 3x2x3", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
